// File: rtl/pci_pkg.sv
// Shared definitions for the PCI initiator: FSM state encoding, bus active levels, defaults.
package pci_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_WAIT,
        S_ADDR,
        S_DATA,
        S_ABORT,
        S_TURN
    } state_t;

    // PCI control lines are active low
    localparam logic ASSERTED = 1'b0;
    localparam logic RELEASED = 1'b1;

    localparam int DEF_LEN_W          = 4;
    localparam int DEF_DEVSEL_TIMEOUT = 5;

endpackage

// File: rtl/pci_bus_requester_if.sv
// PCI arbitration and framing lines seen by one initiator (all active low, 1 = released).
interface pci_bus_requester_if;

    logic GNT;
    logic FRAME_in;
    logic IRDY_in;
    logic TRDY;
    logic DEVSEL;
    logic REQ;
    logic FRAME;
    logic IRDY;

    modport master (
        input  GNT, FRAME_in, IRDY_in, TRDY, DEVSEL,
        output REQ, FRAME, IRDY
    );

    modport slave (
        output GNT, FRAME_in, IRDY_in, TRDY, DEVSEL,
        input  REQ, FRAME, IRDY
    );

endinterface

// File: rtl/pci_bus_requester.sv
// PCI initiator: requests the bus, frames address + N data phases, master-aborts on DEVSEL timeout.
// Latency: REQ one edge after start, FRAME one edge after qualified grant; all outputs registered.
// Backpressure: TRDY high stretches a data phase indefinitely; start is ignored unless IDLE.
module pci_bus_requester
    import pci_pkg::*;
#(
    parameter int LEN_W          = DEF_LEN_W,
    parameter int DEVSEL_TIMEOUT = DEF_DEVSEL_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pci_bus_requester_if.master  bus,
    input  logic                 start,
    input  logic [LEN_W-1:0]     length,
    output logic                 busy,
    output logic                 xfer,
    output logic                 done,
    output logic                 abort,
    output logic [LEN_W-1:0]     remaining
);

    localparam int CNT_W = $clog2(DEVSEL_TIMEOUT + 1);

    state_t             state, state_nx;
    logic [LEN_W-1:0]   rem_nx;
    logic [CNT_W-1:0]   dev_cnt, dev_cnt_nx;
    logic               claimed, claimed_nx;
    logic               req_q, frame_q, irdy_q;
    logic               req_nx, frame_nx, irdy_nx;
    logic               busy_nx, xfer_nx, done_nx, abort_nx;
    logic               bus_idle;

    assign bus_idle  = (bus.FRAME_in == RELEASED) && (bus.IRDY_in == RELEASED);
    assign bus.REQ   = req_q;
    assign bus.FRAME = frame_q;
    assign bus.IRDY  = irdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            remaining <= '0;
            dev_cnt   <= '0;
            claimed   <= 1'b0;
            req_q     <= RELEASED;
            frame_q   <= RELEASED;
            irdy_q    <= RELEASED;
            busy      <= 1'b0;
            xfer      <= 1'b0;
            done      <= 1'b0;
            abort     <= 1'b0;
        end else begin
            state     <= state_nx;
            remaining <= rem_nx;
            dev_cnt   <= dev_cnt_nx;
            claimed   <= claimed_nx;
            req_q     <= req_nx;
            frame_q   <= frame_nx;
            irdy_q    <= irdy_nx;
            busy      <= busy_nx;
            xfer      <= xfer_nx;
            done      <= done_nx;
            abort     <= abort_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        rem_nx     = remaining;
        dev_cnt_nx = dev_cnt;
        claimed_nx = claimed;
        xfer_nx    = 1'b0;
        abort_nx   = abort;

        case (state)
            S_IDLE: begin
                if (start && (length != '0)) begin
                    rem_nx   = length;
                    abort_nx = 1'b0;
                    state_nx = S_REQ_WAIT;
                end
            end
            S_REQ_WAIT: begin
                if ((bus.GNT == ASSERTED) && bus_idle)
                    state_nx = S_ADDR;
            end
            S_ADDR: begin
                dev_cnt_nx = '0;
                claimed_nx = 1'b0;
                state_nx   = S_DATA;
            end
            S_DATA: begin
                if (bus.DEVSEL == ASSERTED) begin
                    // once claimed, the timeout is dead for the rest of the transfer
                    claimed_nx = 1'b1;
                    if (bus.TRDY == ASSERTED) begin
                        xfer_nx = 1'b1;
                        rem_nx  = remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1))
                            state_nx = S_TURN;
                    end
                end else if (!claimed) begin
                    dev_cnt_nx = dev_cnt + CNT_W'(1);
                    if (dev_cnt_nx == CNT_W'(DEVSEL_TIMEOUT)) begin
                        abort_nx = 1'b1;
                        state_nx = S_ABORT;
                    end
                end
            end
            S_ABORT: state_nx = S_TURN;
            S_TURN:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        // outputs are decoded from the next state so they come straight out of flops
        req_nx   = (state_nx == S_REQ_WAIT) ? ASSERTED : RELEASED;
        frame_nx = ((state_nx == S_ADDR) ||
                    ((state_nx == S_DATA) && (rem_nx > LEN_W'(1)))) ? ASSERTED : RELEASED;
        irdy_nx  = ((state_nx == S_DATA) || (state_nx == S_ABORT)) ? ASSERTED : RELEASED;
        busy_nx  = (state_nx != S_IDLE);
        done_nx  = (state_nx == S_TURN);
    end

endmodule

// File: tb/tb_pci_bus_requester.sv
// Directed bench for pci_bus_requester: transfer-level trace generator feeding a per-cycle scoreboard.
module tb_pci_bus_requester;

    localparam int TMO = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] length = 4'd0;
    logic       busy, xfer, done, abort;
    logic [3:0] remaining;

    pci_bus_requester_if bus();

    pci_bus_requester #(.LEN_W(4), .DEVSEL_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .start(start), .length(length),
        .busy(busy), .xfer(xfer), .done(done), .abort(abort),
        .remaining(remaining)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [10:0] exp_q[$];
    int req_low = 0, frame_low = 0, irdy_low = 0, xfer_cnt = 0;
    int since_addr = 0, done_pos = 0;

    // model state carried across transfers
    logic m_abort = 1'b0;
    int   m_rem   = 0;

    function automatic logic [10:0] mk(input logic rq, fr, ir, bz, xf, dn, ab, input int rm);
        return {rq, fr, ir, bz, xf, dn, ab, 4'(rm)};
    endfunction

    // scoreboard + activity monitors, sampled on the falling edge
    always @(negedge clk) begin
        logic [10:0] e, got;
        got = {bus.REQ, bus.FRAME, bus.IRDY, busy, xfer, done, abort, remaining};
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL trace t=%0t req/frame/irdy/busy/xfer/done/abort/rem got=%b required=%b",
                         $time, got, e);
            end
        end
        if (rst_n) begin
            if (!bus.REQ)   req_low++;
            if (!bus.FRAME) frame_low++;
            if (!bus.IRDY)  irdy_low++;
            if (xfer)       xfer_cnt++;
            if (!bus.FRAME && bus.REQ && bus.IRDY) since_addr = 1;
            else since_addr++;
            if (done) done_pos = since_addr;
        end
    end

    task automatic check(input string nm, input int got, input int req);
        n_assert++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, got, req);
        end
    endtask

    // drive inputs for the next rising edge and queue the outputs expected after it
    task automatic cyc(input logic st, input logic [3:0] ln, input logic g, fi, ii, tr, dv,
                       input logic [10:0] e);
        @(negedge clk);
        #2;
        start = st; length = ln;
        bus.GNT = g; bus.FRAME_in = fi; bus.IRDY_in = ii; bus.TRDY = tr; bus.DEVSEL = dv;
        exp_q.push_back(e);
    endtask

    // one complete transfer: stimulus and expected trace derived from the transfer description
    task automatic transfer(input int len, gnt_wait, bus_busy, w0, wrest, dev_late,
                            input bit flaky, sid);
        int  rem, miss, dc, wc, wt;
        bit  claimed, dv, tr, fin, aborted;
        logic fr;
        rem = len; miss = 0; dc = 0; wc = 0;
        claimed = 0; fin = 0; aborted = 0;
        m_abort = 1'b0;
        cyc(1'b1, 4'(len), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, mk(1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,rem));
        for (int i = 0; i < gnt_wait; i++)
            cyc(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, mk(1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,rem));
        for (int i = 0; i < bus_busy; i++)
            cyc(1'b0, 4'd0, (i % 3 == 2), (i % 2 == 1), (i % 2 == 0), 1'b1, 1'b1,
                mk(1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,rem));
        cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, mk(1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,rem));
        fr = (rem > 1) ? 1'b0 : 1'b1;
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, mk(1'b1,fr,1'b0,1'b1,1'b0,1'b0,1'b0,rem));
        while (!fin && dc < 200) begin
            wt = (rem == len) ? w0 : wrest;
            dv = (dc < dev_late) || (flaky && claimed && (dc % 2 == 1));
            tr = dv ? 1'b0 : (wc < wt);
            dc++; wc++;
            if (!dv) claimed = 1;
            else if (!claimed) miss++;
            if (dv && !claimed && miss == TMO) begin
                cyc(sid, 4'd7, dc[0], 1'b0, 1'b0, tr, dv, mk(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,rem));
                m_abort = 1'b1; aborted = 1; fin = 1;
            end else if (!dv && !tr) begin
                rem--; wc = 0;
                if (rem == 0) begin
                    cyc(sid, 4'd7, dc[0], 1'b0, 1'b0, tr, dv, mk(1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,0));
                    fin = 1;
                end else begin
                    fr = (rem > 1) ? 1'b0 : 1'b1;
                    cyc(sid, 4'd7, dc[0], 1'b0, 1'b0, tr, dv, mk(1'b1,fr,1'b0,1'b1,1'b1,1'b0,1'b0,rem));
                end
            end else begin
                fr = (rem > 1) ? 1'b0 : 1'b1;
                cyc(sid, 4'd7, dc[0], 1'b0, 1'b0, tr, dv, mk(1'b1,fr,1'b0,1'b1,1'b0,1'b0,1'b0,rem));
            end
        end
        if (!fin) check("model_bound", dc, -1);
        if (aborted)
            cyc(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, mk(1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,rem));
        // start during TURN must be dropped
        cyc(1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, mk(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,m_abort,rem));
        cyc(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, mk(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,m_abort,rem));
        m_rem = rem;
        @(negedge clk);
        #1;
    endtask

    int r0, f0, i0, x0;
    task automatic snap();
        r0 = req_low; f0 = frame_low; i0 = irdy_low; x0 = xfer_cnt;
    endtask

    initial begin
        bus.GNT = 1'b1; bus.FRAME_in = 1'b1; bus.IRDY_in = 1'b1; bus.TRDY = 1'b1; bus.DEVSEL = 1'b1;
        @(negedge clk);
        check("reset_req", bus.REQ, 1);
        check("reset_frame", bus.FRAME, 1);
        check("reset_irdy", bus.IRDY, 1);
        check("reset_busy", busy, 0);
        check("reset_rem", remaining, 0);
        check("reset_abort", abort, 0);
        #2 rst_n = 1'b1;

        // length 3, grant two cycles after start, zero wait states
        snap();
        transfer(3, 1, 0, 0, 0, 0, 1'b0, 1'b0);
        check("t3_req_low", req_low - r0, 2);
        check("t3_frame_low", frame_low - f0, 3);
        check("t3_xfers", xfer_cnt - x0, 3);
        check("t3_done_pos", done_pos, 5);

        // granted while bus busy for 4 cycles
        snap();
        transfer(2, 0, 4, 0, 0, 0, 1'b0, 1'b0);
        check("busy_req_low", req_low - r0, 5);

        // TRDY withheld for 3 cycles in first phase
        snap();
        transfer(2, 0, 0, 3, 0, 0, 1'b0, 1'b0);
        check("wait_irdy_low", irdy_low - i0, 5);
        check("wait_xfers", xfer_cnt - x0, 2);

        // single phase: FRAME low only in ADDR
        snap();
        transfer(1, 2, 0, 0, 0, 0, 1'b0, 1'b0);
        check("one_frame_low", frame_low - f0, 1);
        check("one_irdy_low", irdy_low - i0, 1);

        // no DEVSEL: master abort
        snap();
        transfer(3, 0, 0, 0, 0, 100, 1'b0, 1'b0);
        check("abort_irdy_low", irdy_low - i0, 6);
        check("abort_xfers", xfer_cnt - x0, 0);
        check("abort_sticky", abort, 1);

        // length 0 start ignored, abort kept
        cyc(1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, mk(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,m_abort,m_rem));
        cyc(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, mk(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,m_abort,m_rem));
        @(negedge clk); #1;
        check("len0_req", bus.REQ, 1);

        // late claim, start pulsed during DATA
        snap();
        transfer(3, 0, 0, 1, 1, 3, 1'b0, 1'b1);
        check("sid_xfers", xfer_cnt - x0, 3);
        check("sid_abort_cleared", abort, 0);

        // maximum length, DEVSEL bouncing after claim must not time out
        snap();
        transfer(15, 0, 0, 0, 0, 3, 1'b1, 1'b0);
        check("max_xfers", xfer_cnt - x0, 15);

        // reset in the middle of DATA with remaining = 3
        cyc(1'b1, 4'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, mk(1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,4));
        cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, mk(1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,4));
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,4));
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,3));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_req", bus.REQ, 1);
        check("rst_frame", bus.FRAME, 1);
        check("rst_irdy", bus.IRDY, 1);
        check("rst_rem", remaining, 0);
        check("rst_busy", busy, 0);
        check("rst_xfer", xfer, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        m_abort = 1'b0; m_rem = 0;
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
